unified_mem_ctrl: RTL and testbench

Parametrised unified memory controller that replaces the separate fixed instruction and data memories of the single-cycle top with one shared word array behind two request/ready ports. It sits between a multi-cycle RV32 core and storage. It arbitrates instruction fetches against data accesses, inserts configurable wait states, performs byte/halfword stores with lane enables, and sign/zero-extends loads.

---
 rtl/umem_pkg.sv | 17 +
 rtl/umem_array.sv | 24 ++
 rtl/unified_mem_ctrl.sv | 176 +++++++++++++++++
 tb/tb_unified_mem_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/umem_pkg.sv
// Shared types and constants for the unified memory controller.
package umem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef enum logic {GNT_INSTR, GNT_DATA} grant_e;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return (size == 2'b11) || (size == SZ_H && lo[0]) || (size == SZ_W && lo != 2'b00);
  endfunction

endpackage

// File: rtl/umem_array.sv
// Word array: synchronous write with byte enables, combinational read.
module umem_array #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter     INIT_FILE   = ""
) (
  input  logic                           clk,
  input  logic [XLEN/8-1:0]              be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [XLEN-1:0]                wdata,
  output logic [XLEN-1:0]                rdata
);

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < XLEN / 8; b++) begin
      if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/unified_mem_ctrl.sv
// Shared instruction/data memory with round-robin arbitration and WAIT_STATES wait cycles.
// Define UMEM_BYTE_EN for byte/half stores and sign/zero-extended loads; otherwise data is word-only.
module unified_mem_ctrl
  import umem_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1,
  parameter     INIT_FILE   = ""
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_ready,
  output logic [XLEN-1:0] i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [1:0]      d_size,
  input  logic            d_unsigned,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_ready,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int NB = XLEN / 8;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  state_e           state, state_nxt;
  grant_e           gnt, last_grant, sel;
  logic [CNT_W-1:0] cnt;
  logic             take, go_resp, is_data, err;
  logic [XLEN-1:0]  lat_addr, lat_wdata, cur_addr, cur_wdata;
  logic [1:0]       lat_size, cur_size;
  logic             lat_we, lat_uns, cur_we, cur_uns;
  logic [NB-1:0]    be, wr_be;
  logic [XLEN-1:0]  wr_data, rd_word, ld_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sel       = gnt;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          take = 1'b1;
          // On a tie, the port not served last wins
          if (d_req && (!i_req || last_grant == GNT_INSTR)) sel = GNT_DATA;
          else                                               sel = GNT_INSTR;
          if (WAIT_STATES > 0) state_nxt = WAIT;
          else                 state_nxt = RESP;
        end
      end
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign go_resp = (state != RESP) && (state_nxt == RESP);
  assign is_data = (sel == GNT_DATA);

  // In IDLE the response path looks at the live request so WAIT_STATES=0 still works
  always_comb begin
    if (state == IDLE) begin
      cur_addr  = is_data ? d_addr : i_addr;
      cur_size  = d_size;
      cur_we    = d_we;
      cur_uns   = d_unsigned;
      cur_wdata = d_wdata;
    end else begin
      cur_addr  = lat_addr;
      cur_size  = lat_size;
      cur_we    = lat_we;
      cur_uns   = lat_uns;
      cur_wdata = lat_wdata;
    end
  end

`ifdef UMEM_BYTE_EN
  logic [XLEN-1:0] shifted;
  logic            unused_ok;

  always_comb begin
    err     = misaligned(cur_size, cur_addr[1:0]);
    shifted = rd_word >> {cur_addr[1:0], 3'b000};
    wr_data = cur_wdata << {cur_addr[1:0], 3'b000};
    be      = '1;
    ld_data = rd_word;
    case (cur_size)
      SZ_B: begin
        be      = NB'(1) << cur_addr[1:0];
        ld_data = cur_uns ? XLEN'(shifted[7:0]) : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        be      = NB'(3) << cur_addr[1:0];
        ld_data = cur_uns ? XLEN'(shifted[15:0]) : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

  assign unused_ok = ^{cur_addr, shifted};
`else
  logic unused_ok;

  assign err       = (cur_addr[1:0] != 2'b00);
  assign be        = '1;
  assign ld_data   = rd_word;
  assign wr_data   = cur_wdata;
  assign unused_ok = ^{cur_addr, cur_size, cur_uns};
`endif

  assign wr_be = (state == RESP && gnt == GNT_DATA && lat_we && !err) ? be : '0;

  umem_array #(
    .XLEN(XLEN), .DEPTH_WORDS(DEPTH_WORDS), .INIT_FILE(INIT_FILE)
  ) u_array (
    .clk(clk), .be(wr_be), .addr(cur_addr[AW+1:2]), .wdata(wr_data), .rdata(rd_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt        <= GNT_INSTR;
      last_grant <= GNT_INSTR;
      cnt        <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_size   <= SZ_W;
      lat_we     <= 1'b0;
      lat_uns    <= 1'b0;
      i_ready    <= 1'b0;
      i_rdata    <= '0;
      d_ready    <= 1'b0;
      d_rdata    <= '0;
      d_err      <= 1'b0;
    end else begin
      if (take) begin
        gnt        <= sel;
        last_grant <= sel;
        cnt        <= CNT_LOAD;
        lat_addr   <= cur_addr;
        lat_wdata  <= cur_wdata;
        lat_size   <= cur_size;
        lat_we     <= cur_we;
        lat_uns    <= cur_uns;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      i_ready <= 1'b0;
      i_rdata <= '0;
      d_ready <= 1'b0;
      d_rdata <= '0;
      d_err   <= 1'b0;
      if (go_resp) begin
        if (is_data) begin
          d_ready <= 1'b1;
          d_err   <= err;
          d_rdata <= (err || cur_we) ? '0 : ld_data;
        end else begin
          i_ready <= 1'b1;
          i_rdata <= rd_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Randomized bench for unified_mem_ctrl against a byte-addressed reference memory.
module tb_unified_mem_ctrl;

  localparam int XLEN  = 32;
  localparam int DEPTH = 64;
  localparam int WS    = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [1:0]  d_size = 2'b10;
  logic        d_unsigned = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_err;

  int checks = 0;
  int errors = 0;

  // Reference memory: DEPTH*4 bytes, little-endian, address taken modulo its size
  logic [7:0] mem_b [DEPTH*4];

  always #5 clk = ~clk;

  unified_mem_ctrl #(
    .XLEN(XLEN), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err)
  );

  function automatic logic model_err(input logic [31:0] a, input logic [1:0] sz);
`ifdef UMEM_BYTE_EN
    return (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) || (sz == 2'b10 && a % 4 != 0);
`else
    return a % 4 != 0;
`endif
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int b;
    b = int'(a % (DEPTH * 4)) / 4 * 4;
    return {mem_b[b+3], mem_b[b+2], mem_b[b+1], mem_b[b]};
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic u);
    int b;
    b = int'(a % (DEPTH * 4));
    if (model_err(a, sz)) return 32'h0;
`ifdef UMEM_BYTE_EN
    if (sz == 2'b00) return u ? {24'h0, mem_b[b]} : {{24{mem_b[b][7]}}, mem_b[b]};
    if (sz == 2'b01) return u ? {16'h0, mem_b[b+1], mem_b[b]}
                              : {{16{mem_b[b+1][7]}}, mem_b[b+1], mem_b[b]};
`endif
    return model_word(a);
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int b, n;
    b = int'(a % (DEPTH * 4));
    n = 4;
`ifdef UMEM_BYTE_EN
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
`endif
    if (!model_err(a, sz)) begin
      for (int i = 0; i < n; i++) mem_b[b+i] = wd[8*i +: 8];
    end
  endtask

  // One data access; fields are scrambled after the grant edge to prove they are latched
  task automatic d_access(input logic we, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd, input string name);
    logic [31:0] exp_d;
    logic        exp_e;
    int          cyc;
    exp_e = model_err(a, sz);
    exp_d = model_load(a, sz, u);
    @(negedge clk);
    d_req = 1'b1; d_we = we; d_size = sz; d_unsigned = u; d_addr = a; d_wdata = wd;
    cyc = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (d_ready) break;
      if (cyc == 1) begin
        d_addr = $urandom; d_wdata = $urandom; d_size = 2'($urandom);
        d_we = ~d_we; d_unsigned = ~d_unsigned;
      end
    end
    d_req = 1'b0;
    checks++;
    if (cyc !== 1 + WS || d_ready !== 1'b1) begin
      errors++; $display("FAIL %s latency: got %0d cycles ready=%b, expected %0d", name, cyc, d_ready, 1 + WS);
    end
    checks++;
    if (d_err !== exp_e) begin
      errors++; $display("FAIL %s d_err: got %b expected %b (addr %h size %b)", name, d_err, exp_e, a, sz);
    end
    if (!we || exp_e) begin
      checks++;
      if (d_rdata !== exp_d) begin
        errors++; $display("FAIL %s d_rdata: got %h expected %h (addr %h size %b)", name, d_rdata, exp_d, a, sz);
      end
    end
    if (we) model_store(a, sz, wd);
    @(posedge clk); #1;
    checks++;
    if (d_ready !== 1'b0 || d_rdata !== 32'h0 || d_err !== 1'b0) begin
      errors++; $display("FAIL %s after ready: ready=%b rdata=%h err=%b expected all zero", name, d_ready, d_rdata, d_err);
    end
  endtask

  task automatic i_fetch(input logic [31:0] a, input string name);
    logic [31:0] exp_d;
    int          cyc;
    exp_d = model_word(a);
    @(negedge clk);
    i_req = 1'b1; i_addr = a;
    cyc = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (i_ready) break;
      if (cyc == 1) i_addr = $urandom;
    end
    i_req = 1'b0;
    checks++;
    if (cyc !== 1 + WS || i_ready !== 1'b1) begin
      errors++; $display("FAIL %s latency: got %0d cycles ready=%b, expected %0d", name, cyc, i_ready, 1 + WS);
    end
    checks++;
    if (i_rdata !== exp_d) begin
      errors++; $display("FAIL %s i_rdata: got %h expected %h (addr %h)", name, i_rdata, exp_d, a);
    end
    @(posedge clk); #1;
    checks++;
    if (i_ready !== 1'b0 || i_rdata !== 32'h0) begin
      errors++; $display("FAIL %s after ready: ready=%b rdata=%h expected zero", name, i_ready, i_rdata);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (i_ready !== 1'b0 || d_ready !== 1'b0 || i_rdata !== 32'h0 || d_rdata !== 32'h0 || d_err !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: i_ready=%b d_ready=%b i_rdata=%h d_rdata=%h d_err=%b expected all zero",
                         i_ready, d_ready, i_rdata, d_rdata, d_err);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (i_ready !== 1'b0 || d_ready !== 1'b0) begin
      errors++; $display("FAIL reset_idle: i_ready=%b d_ready=%b expected 0", i_ready, d_ready);
    end
  endtask

  task automatic test_fill();
    for (int w = 0; w < DEPTH; w++) d_access(1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom, "fill");
  endtask

  task automatic test_fetch();
    d_access(1'b1, 2'b10, 1'b0, 32'h8, 32'h0050_0093, "fetch_setup");
    i_fetch(32'h0000_0008, "fetch_0x8");
    i_fetch(32'hFFFF_FF0B, "fetch_wrap");
  endtask

  task automatic test_byte_ops();
    d_access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, "store_deadbeef");
    d_access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, "lb_0x13");
    d_access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, "lbu_0x13");
    d_access(1'b1, 2'b00, 1'b0, 32'h11, 32'h55, "sb_0x11");
    d_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "lw_0x10");
    d_access(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, "lh_0x12");
  endtask

  task automatic test_misaligned();
    d_access(1'b1, 2'b01, 1'b0, 32'h21, 32'h1234, "sh_0x21");
    d_access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, "lw_0x20");
    d_access(1'b0, 2'b11, 1'b0, 32'h24, 32'h0, "illegal_size");
    d_access(1'b0, 2'b10, 1'b0, 32'h26, 32'h0, "lw_0x26");
  endtask

  task automatic test_arbitration();
    logic [31:0] ia, da;
    int          cyc, n;
    ia = 32'h44; da = 32'h48;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    i_req = 1'b1; i_addr = ia;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_unsigned = 1'b0; d_addr = da;
    cyc = 0; n = 0;
    while (n < 4 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (i_ready && d_ready) begin
        checks++; errors++; $display("FAIL arb_both_ready: cycle %0d both ready, expected one", cyc);
      end else if (i_ready || d_ready) begin
        checks++;
        if (d_ready !== (n % 2 == 0)) begin
          errors++; $display("FAIL arb_order: completion %0d d_ready=%b expected %b", n, d_ready, n % 2 == 0);
        end
        checks++;
        if (cyc !== 1 + WS + n * (2 + WS)) begin
          errors++; $display("FAIL arb_timing: completion %0d at cycle %0d expected %0d", n, cyc, 1 + WS + n * (2 + WS));
        end
        checks++;
        if (d_ready ? (d_rdata !== model_word(da)) : (i_rdata !== model_word(ia))) begin
          errors++; $display("FAIL arb_data: completion %0d got %h expected %h", n,
                             d_ready ? d_rdata : i_rdata, d_ready ? model_word(da) : model_word(ia));
        end
        n++;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL arb_count: got %0d completions expected 4", n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_store();
    logic [31:0] old;
    int          seen;
    old = model_word(32'h30);
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 32'h30; d_wdata = ~old;
    @(posedge clk); #1;
    reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
    #1;
    checks++;
    if (d_ready !== 1'b0 || d_err !== 1'b0 || d_rdata !== 32'h0) begin
      errors++; $display("FAIL midreset_outputs: ready=%b err=%b rdata=%h expected zero", d_ready, d_err, d_rdata);
    end
    @(negedge clk); reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (d_ready || i_ready) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL midreset_ready: got %0d ready pulses expected 0", seen);
    end
    d_access(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, "midreset_load");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [1:0]  sz;
    for (int n = 0; n < 150; n++) begin
      a  = $urandom;
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) i_fetch(a, "rand_fetch");
      else d_access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, "rand_data");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill();
    test_fetch();
    test_byte_ops();
    test_misaligned();
    test_arbitration();
    test_reset_mid_store();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
